// File: rtl/usb_rx.sv
// Full-speed USB receive front end: line synchronizer, DPLL bit recovery, NRZI
// decode, bit unstuffing, byte assembly and SE0 bus-reset detection.
module usb_rx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int RESET_CYCLES = 120
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_dp,
   input  logic       rx_dm,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_active,
   output logic       rx_error,
   output logic       usb_reset
);
   localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam logic [PW-1:0] PHASE_MID  = PW'(CLKS_PER_BIT / 2);
   localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
   localparam logic [RW-1:0] SE0_MAX    = RW'(RESET_CYCLES);

   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_SE1 = 2'b11;

   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} state_t;

   state_t        state, state_next;
   logic [1:0]    line_meta, line, line_q, prev;
   logic [PW-1:0] phase_q, phase;
   logic          strobe, decoded, line_jk;
   logic [2:0]    sync_cnt, ones, bit_cnt;
   logic          j_seen;
   logic [7:0]    shreg;
   logic [RW-1:0] se0_cnt;
   logic          take_bit, err_now;

   // NOTE: nothing may read line_meta except the second stage; it can be metastable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_meta <= LS_J;
         line      <= LS_J;
         line_q    <= LS_J;
         phase_q   <= '0;
      end else begin
         line_meta <= {rx_dp, rx_dm};
         line      <= line_meta;
         line_q    <= line;
         phase_q   <= phase;
      end
   end

   // Phase is zero in the first cycle a new line state is visible, so the
   // strobe lands mid-bit even when the previous bit was a clock short or long.
   assign phase     = (line != line_q)        ? '0 :
                      (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
   assign strobe    = (phase == PHASE_MID);
   assign decoded   = (line == prev);
   assign line_jk   = (line == LS_J) || (line == LS_K);
   assign usb_reset = (se0_cnt == SE0_MAX) && (line == LS_SE0);
   assign rx_active = (state == DATA) || (state == EOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      take_bit   = 1'b0;
      err_now    = 1'b0;
      if (usb_reset) begin
         state_next = IDLE;
      end else if (strobe) begin
         case (state)
            IDLE: if (line == LS_K) state_next = SYNC;
            SYNC: begin
               if (line == LS_K && prev == LS_K)
                  state_next = DATA;
               else if (line == LS_SE0 || decoded || sync_cnt == 3'd7)
                  state_next = IDLE;
            end
            DATA: begin
               if (line == LS_SE0) begin
                  state_next = EOP;
                  err_now    = (bit_cnt != 3'd0);
               end else if (line == LS_SE1) begin
                  state_next = ABORT;
                  err_now    = 1'b1;
               end else if (ones == 3'd6) begin
                  if (decoded) begin
                     state_next = ABORT;
                     err_now    = 1'b1;
                  end
               end else begin
                  take_bit = 1'b1;
               end
            end
            EOP: begin
               if (line == LS_J)                        state_next = IDLE;
               else if (line == LS_K || line == LS_SE1) state_next = ABORT;
            end
            ABORT: if (line == LS_J && j_seen) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses <= only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev     <= LS_J;
         sync_cnt <= '0;
         ones     <= '0;
         bit_cnt  <= '0;
         j_seen   <= 1'b0;
         shreg    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_error <= 1'b0;
         se0_cnt  <= '0;
      end else begin
         rx_valid <= 1'b0;
         rx_error <= err_now;

         if (line == LS_SE0) begin
            if (se0_cnt != SE0_MAX) se0_cnt <= se0_cnt + 1'b1;
         end else begin
            se0_cnt <= '0;
         end

         if (strobe) prev <= line;

         sync_cnt <= (state == SYNC) ? sync_cnt + {2'b00, strobe} : 3'd0;
         j_seen   <= (state != ABORT) ? 1'b0 :
                     strobe          ? (line == LS_J) : j_seen;

         // The trailing KK of SYNC already counts as the first one of a run.
         if (state == SYNC && state_next == DATA) begin
            ones    <= 3'd1;
            bit_cnt <= 3'd0;
         end else if (state == DATA && strobe && line_jk) begin
            ones <= decoded ? ones + 3'd1 : 3'd0;
         end

         if (take_bit) begin
            shreg   <= {decoded, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_data  <= {decoded, shreg[7:1]};
               rx_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/usb_rx.md
USB_RX -- requirements
Module: usb_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clk cycles per full-speed bit time (48 MHz clk, 12 Mbit/s line).
REQ-002 Parameter RESET_CYCLES, default 120: consecutive SE0 clk cycles before usb_reset asserts (2.5 us at 48 MHz).
REQ-003 clk  input  1  receive clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_dp  input  1  raw D+ line, asynchronous to clk.
REQ-006 rx_dm  input  1  raw D- line, asynchronous to clk.
REQ-007 rx_data  output  8  received byte, LSB = first bit on line; valid when rx_valid=1.
REQ-008 rx_valid  output  1  one-cycle strobe per completed byte.
REQ-009 rx_active  output  1  high from SYNC detection until EOP completion or error abort.
REQ-010 rx_error  output  1  one-cycle strobe on bit-stuff violation or partial byte at EOP.
REQ-011 usb_reset  output  1  synchronous active-high bus-reset indication to the SIE.

Function
REQ-012 rx_dp and rx_dm SHALL each pass a 2-FF synchronizer; line state is decoded from synchronized values: J=10, K=01, SE0=00, SE1=11.
REQ-013 DPLL: a phase counter 0..CLKS_PER_BIT-1 SHALL reset to 0 on any synchronized line-state change and otherwise increment with wrap; bit_strobe asserts when phase == CLKS_PER_BIT/2.
REQ-014 NRZI decode at bit_strobe: decoded bit = 1 if the sampled state equals the previous sampled state, else 0; the previous state is updated on every strobe.
REQ-015 FSM states: IDLE, SYNC, DATA, EOP, ABORT; reset state IDLE.
REQ-016 IDLE -> SYNC on the first K sampled at bit_strobe.
REQ-017 SYNC: decoded 0 stays; decoded 1 (KK) -> DATA with rx_active=1 from the next cycle; SE0 or more than 7 strobes without KK -> IDLE.
REQ-018 DATA: the ones counter is initialised to 1 on entry, increments on decoded 1, and clears on decoded 0.
REQ-019 When the ones counter is 6, the next decoded bit SHALL be discarded as a stuff bit if 0; if 1, the block SHALL pulse rx_error and go to ABORT.
REQ-020 Non-stuff bits SHALL shift in LSB-first; on the 8th bit, rx_data loads the byte and rx_valid pulses one cycle later than that bit's strobe, and the bit count wraps to 0.
REQ-021 SE0 at bit_strobe in DATA -> EOP; if the bit count != 0, rx_error pulses and the partial byte is dropped (no rx_valid).
REQ-022 EOP: a J at bit_strobe -> IDLE with rx_active low the following cycle; K or SE1 -> ABORT.
REQ-023 SE1 at bit_strobe in DATA SHALL pulse rx_error and go to ABORT.
REQ-024 ABORT: rx_active low immediately; return to IDLE after J is sampled at 2 consecutive strobes.
REQ-025 rx_valid and rx_error SHALL never assert while rx_active is low, except the rx_error cycle that coincides with abort entry.
REQ-026 The SE0 counter SHALL increment each cycle synchronized SE0 is present, saturate at RESET_CYCLES, and clear on any non-SE0 cycle.
REQ-027 usb_reset=1 while the SE0 counter equals RESET_CYCLES; it deasserts on the first non-SE0 cycle.
REQ-028 While usb_reset=1, the FSM SHALL be held in IDLE.
REQ-029 rx_data is held between strobes and is not cleared after rx_valid.

Reset
REQ-030 rst_n low SHALL asynchronously force: FSM IDLE, all counters 0, synchronizers and previous state to J, and rx_data=0, rx_valid=0, rx_active=0, rx_error=0, usb_reset=0.
REQ-031 Reset mid-packet SHALL discard the packet; after rst_n rises, no rx_valid occurs until a new SYNC is received.

Verification
REQ-032 SYNC + bytes 0x69, 0x00, 0x10 + EOP (SE0 2 bits, J) -> three rx_valid pulses with rx_data 0x69, 0x00, 0x10; rx_active high throughout and low after J; rx_error never asserts.
REQ-033 Byte 0xFF with a correct stuff bit inserted after the 6th one -> rx_data=0xFF, no error.
REQ-034 Seven consecutive ones in DATA (no stuff bit) -> one rx_error pulse, rx_active low, no rx_valid for that byte; the next valid packet is received normally.
REQ-035 EOP after 0x2D plus 3 extra bits -> rx_valid for 0x2D only, then one rx_error pulse.
REQ-036 SE0 held 119 cycles -> usb_reset stays 0; SE0 held 130 cycles -> usb_reset=1 from cycle 120 until the first J cycle.
REQ-037 Bit period jittered ±1 clk every bit at CLKS_PER_BIT=4 -> all bytes received error-free; rst_n pulsed mid-byte -> outputs 0 immediately, no spurious rx_valid afterward.
